// File: rtl/ysyx_040066_mem_arb.sv
// Memory port arbiter: NRD read clients (round-robin) and one write client
// share a single downstream port, with write priority, anti-starvation and abort absorption.
module ysyx_040066_mem_arb #(
    parameter int NRD   = 2,
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int BEATS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        c_rd_req,
    input  logic [NRD-1:0]        c_rd_burst,
    input  logic [NRD*3-1:0]      c_rd_len,
    input  logic [NRD*AW-1:0]     c_rd_addr,
    output logic [NRD-1:0]        c_rd_ready,
    output logic [NRD-1:0]        c_rd_last,
    output logic [NRD-1:0]        c_rd_err,
    output logic [DW-1:0]         c_rd_data,
    input  logic                  wr_req,
    input  logic                  wr_burst,
    input  logic [2:0]            wr_len,
    input  logic [7:0]            wr_mask,
    input  logic [AW-1:0]         wr_addr,
    input  logic [BEATS*DW-1:0]   wr_data,
    output logic                  wr_ready,
    output logic                  wr_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic                  m_burst,
    output logic [2:0]            m_len,
    output logic [7:0]            m_mask,
    output logic [AW-1:0]         m_addr,
    output logic [BEATS*DW-1:0]   m_wdata,
    input  logic                  m_ready,
    input  logic                  m_last,
    input  logic                  m_err,
    input  logic [DW-1:0]         m_rdata
);

    localparam int IW = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int CW = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state;
    logic [IW-1:0] g;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] rr_next;
    logic          gnt_wr;
    logic          wr_last;
    logic          abt;
    logic [CW-1:0] cnt;

    logic          any_rd;
    logic          found;
    logic          sel_req;
    logic          sel_burst;
    logic [2:0]    sel_len;
    logic [AW-1:0] sel_addr;
    logic          req_g;
    logic          live;
    logic          rd_done;

    // Round-robin: first pending client at or above rr_ptr, else wrap to the lowest pending one.
    always_comb begin
        any_rd  = |c_rd_req;
        rr_pick = rr_ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (!found && c_rd_req[i] && (32'(rr_ptr) <= i)) begin
                rr_pick = IW'(i);
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NRD; i++) begin
            if (!found && c_rd_req[i]) begin
                rr_pick = IW'(i);
                found   = 1'b1;
            end
        end
        rr_next = (32'(rr_pick) == 32'(NRD - 1)) ? '0 : rr_pick + 1'b1;
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_burst = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (g == IW'(i)) begin
                sel_req   = c_rd_req[i];
                sel_burst = c_rd_burst[i];
                sel_len   = c_rd_len[i*3 +: 3];
                sel_addr  = c_rd_addr[i*AW +: AW];
            end
        end
    end

    assign m_we    = gnt_wr;
    assign m_burst = gnt_wr ? wr_burst : sel_burst;
    assign m_len   = gnt_wr ? wr_len   : sel_len;
    assign m_mask  = gnt_wr ? wr_mask  : '0;
    assign m_addr  = gnt_wr ? wr_addr  : sel_addr;
    assign m_wdata = wr_data;

    // Once the granted client lets go of req, every remaining beat is swallowed.
    assign req_g   = gnt_wr ? wr_req : sel_req;
    assign live    = req_g & ~abt;
    assign rd_done = m_ready & (m_last | ~sel_burst | m_err | (cnt == CW'(BEATS - 1)));

    always_comb begin
        c_rd_ready = '0;
        c_rd_last  = '0;
        c_rd_err   = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if ((state == RD) && (g == IW'(i)) && live && m_ready) begin
                c_rd_ready[i] = 1'b1;
                c_rd_last[i]  = m_last | ~sel_burst;
                c_rd_err[i]   = m_err;
            end
        end
    end

    assign c_rd_data = m_rdata;
    assign wr_ready  = (state == WR) & live & m_ready;
    assign wr_err    = (state == WR) & live & m_ready & m_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            g       <= '0;
            gnt_wr  <= 1'b0;
            rr_ptr  <= '0;
            wr_last <= 1'b0;
            abt     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    abt <= 1'b0;
                    cnt <= '0;
                    if (wr_req && !(wr_last && any_rd)) begin
                        state   <= WR;
                        gnt_wr  <= 1'b1;
                        wr_last <= 1'b1;
                        m_req   <= 1'b1;
                    end else if (any_rd) begin
                        state   <= RD;
                        gnt_wr  <= 1'b0;
                        g       <= rr_pick;
                        rr_ptr  <= rr_next;
                        wr_last <= 1'b0;
                        m_req   <= 1'b1;
                    end
                end
                RD: begin
                    if (!req_g) abt <= 1'b1;
                    if (m_ready) cnt <= cnt + 1'b1;
                    if (rd_done) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                    end
                end
                WR: begin
                    if (!req_g) abt <= 1'b1;
                    if (m_ready) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040066_mem_arb.sv
// Bench for ysyx_040066_mem_arb: randomized clients and downstream responder checked
// against a request-level arbitration model (pending sets, rr pointer, last-was-write flag).
module tb_ysyx_040066_mem_arb;

    localparam int NRD   = 2;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BEATS = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NRD-1:0]      c_rd_req = '0;
    logic [NRD-1:0]      c_rd_burst = '0;
    logic [NRD*3-1:0]    c_rd_len = '0;
    logic [NRD*AW-1:0]   c_rd_addr = '0;
    logic [NRD-1:0]      c_rd_ready, c_rd_last, c_rd_err;
    logic [DW-1:0]       c_rd_data;
    logic                wr_req = 1'b0, wr_burst = 1'b0;
    logic [2:0]          wr_len = '0;
    logic [7:0]          wr_mask = '0;
    logic [AW-1:0]       wr_addr = '0;
    logic [BEATS*DW-1:0] wr_data = '0;
    logic                wr_ready, wr_err;
    logic                m_req, m_we, m_burst;
    logic [2:0]          m_len;
    logic [7:0]          m_mask;
    logic [AW-1:0]       m_addr;
    logic [BEATS*DW-1:0] m_wdata;
    logic                m_ready = 1'b0, m_last = 1'b0, m_err = 1'b0;
    logic [DW-1:0]       m_rdata = '0;

    always #5 clk = ~clk;

    ysyx_040066_mem_arb #(.NRD(NRD), .AW(AW), .DW(DW), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .c_rd_req(c_rd_req), .c_rd_burst(c_rd_burst), .c_rd_len(c_rd_len), .c_rd_addr(c_rd_addr),
        .c_rd_ready(c_rd_ready), .c_rd_last(c_rd_last), .c_rd_err(c_rd_err), .c_rd_data(c_rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .m_req(m_req), .m_we(m_we), .m_burst(m_burst), .m_len(m_len), .m_mask(m_mask),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_last(m_last), .m_err(m_err), .m_rdata(m_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Client-level model state
    bit                  rp [NRD];
    logic [AW-1:0]       ra [NRD];
    bit                  rb [NRD];
    logic [2:0]          rl [NRD];
    bit                  wp;
    logic [AW-1:0]       wa;
    bit                  wb;
    logic [2:0]          wl;
    logic [7:0]          wm;
    logic [BEATS*DW-1:0] wd;
    int                  rr;
    bit                  wrl;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < NRD; i++) begin
            c_rd_req[i]            = rp[i];
            c_rd_burst[i]          = rb[i];
            c_rd_len[i*3 +: 3]     = rl[i];
            c_rd_addr[i*AW +: AW]  = ra[i];
        end
        wr_req   = wp;
        wr_burst = wb;
        wr_len   = wl;
        wr_mask  = wm;
        wr_addr  = wa;
        wr_data  = wd;
    endtask

    task automatic new_read(input int i);
        rp[i] = 1'b1;
        ra[i] = {32'(i + 1), 32'($urandom)};
        rb[i] = 1'($urandom_range(0, 1));
        rl[i] = 3'($urandom);
    endtask

    task automatic new_write();
        wp = 1'b1;
        wa = {32'hFFFF_0000, 32'($urandom)};
        wb = 1'($urandom_range(0, 1));
        wl = 3'($urandom);
        wm = 8'($urandom);
        for (int j = 0; j < BEATS*DW/32; j++) wd[j*32 +: 32] = 32'($urandom);
    endtask

    // Who the arbiter must grant next; NRD stands for the write client.
    task automatic pick(output int w);
        bit any_rd;
        any_rd = 1'b0;
        for (int i = 0; i < NRD; i++) any_rd |= rp[i];
        w = -1;
        if (wp && !(wrl && any_rd)) begin
            w   = NRD;
            wrl = 1'b1;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                int idx;
                idx = (rr + k) % NRD;
                if (w < 0 && rp[idx]) w = idx;
            end
            rr  = (w + 1) % NRD;
            wrl = 1'b0;
        end
    endtask

    // Entered in an idle cycle; leaves in the idle cycle that follows completion.
    task automatic txn(input int w, input bit gaps, input bit faults);
        logic [NRD-1:0] oh;
        int  nb, eb, ab;
        bit  miss_last, aborted, wab;
        m_ready = 1'b0; m_last = 1'b0; m_err = 1'b0;
        apply();
        #1;
        chk("idle_mreq", m_req, 0);
        tick();
        chk("grant_mreq", m_req, 1);
        if (w == NRD) begin
            chk("grant_we", m_we, 1);
            chk("grant_waddr", m_addr, wa);
            chk("grant_wmask", m_mask, wm);
            chk("grant_wlen", m_len, wl);
            chk("grant_wburst", m_burst, wb);
            chk("grant_wdata", m_wdata, wd);
            wab = faults && ($urandom_range(0, 5) == 0);
            if (gaps) repeat ($urandom_range(0, 2)) begin
                m_ready = 1'b0;
                #1;
                chk("wgap_wrdy", wr_ready, 0);
                tick();
            end
            if (wab) begin wp = 1'b0; apply(); end
            m_ready = 1'b1;
            m_err   = faults && ($urandom_range(0, 3) == 0);
            m_rdata = {32'($urandom), 32'($urandom)};
            #1;
            chk("w_ready", wr_ready, wab ? 0 : 1);
            chk("w_err", wr_err, (wab || !m_err) ? 0 : 1);
            chk("w_rdready", c_rd_ready, 0);
            tick();
            wp = 1'b0;
        end else begin
            chk("grant_we", m_we, 0);
            chk("grant_raddr", m_addr, ra[w]);
            chk("grant_rmask", m_mask, 0);
            chk("grant_rlen", m_len, rl[w]);
            chk("grant_rburst", m_burst, rb[w]);
            nb        = rb[w] ? BEATS : 1;
            eb        = (faults && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            ab        = (faults && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            miss_last = faults && rb[w] && ($urandom_range(0, 3) == 0);
            aborted   = 1'b0;
            for (int b = 0; b < nb; b++) begin
                if (gaps) repeat ($urandom_range(0, 2)) begin
                    m_ready = 1'b0;
                    #1;
                    chk("rgap_rdy", c_rd_ready, 0);
                    chk("rgap_wrdy", wr_ready, 0);
                    tick();
                end
                if (b == ab) begin aborted = 1'b1; rp[w] = 1'b0; apply(); end
                m_ready = 1'b1;
                m_err   = (b == eb);
                m_last  = rb[w] ? ((b == nb - 1) && !miss_last) : 1'($urandom_range(0, 1));
                m_rdata = {32'($urandom), 32'($urandom)};
                #1;
                oh = '0;
                if (!aborted) oh[w] = 1'b1;
                chk("beat_rdy", c_rd_ready, oh);
                chk("beat_last", c_rd_last, (m_last || !rb[w]) ? oh : '0);
                chk("beat_err", c_rd_err, m_err ? oh : '0);
                chk("beat_data", c_rd_data, m_rdata);
                chk("beat_wrdy", wr_ready, 0);
                tick();
                m_ready = 1'b0; m_last = 1'b0; m_err = 1'b0;
                if (b == eb) break;
            end
            rp[w] = 1'b0;
        end
        // downstream keeps ready high while idle; nothing may leak through
        m_ready = 1'b1; m_last = 1'b0; m_err = 1'b0;
        apply();
        #1;
        chk("done_mreq", m_req, 0);
        chk("done_rdy", c_rd_ready, 0);
        chk("done_wrdy", wr_ready, 0);
    endtask

    task automatic drain();
        int w;
        for (int n = 0; n < NRD + 2; n++) begin
            bit any;
            any = wp;
            for (int i = 0; i < NRD; i++) any |= rp[i];
            if (!any) break;
            pick(w);
            txn(w, 1'b1, 1'b0);
        end
    endtask

    initial begin
        int w;
        for (int i = 0; i < NRD; i++) begin rp[i] = 0; ra[i] = '0; rb[i] = 0; rl[i] = '0; end
        wp = 0; wa = '0; wb = 0; wl = '0; wm = '0; wd = '0; rr = 0; wrl = 0;

        tick();
        tick();
        m_ready = 1'b1;
        #1;
        chk("rst_mreq", m_req, 0);
        chk("rst_rdy", c_rd_ready, 0);
        chk("rst_last", c_rd_last, 0);
        chk("rst_err", c_rd_err, 0);
        chk("rst_wrdy", wr_ready, 0);
        chk("rst_werr", wr_err, 0);
        rst = 1'b0;
        m_ready = 1'b0;
        tick();

        // lone icache line read
        rp[0] = 1'b1; ra[0] = 64'h8000_0040; rb[0] = 1'b1; rl[0] = 3'd3;
        pick(w);
        txn(w, 1'b0, 1'b0);

        // both readers held: grants alternate
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NRD; i++) if (!rp[i]) new_read(i);
            pick(w);
            txn(w, 1'b1, 1'b0);
        end
        drain();

        // writer and reader 1 held: W,R1,W,R1
        for (int n = 0; n < 4; n++) begin
            if (!wp) new_write();
            if (!rp[1]) new_read(1);
            pick(w);
            txn(w, 1'b1, 1'b0);
        end
        drain();

        // random mix with errors, aborts and missing m_last
        for (int n = 0; n < 60; n++) begin
            bit any;
            for (int i = 0; i < NRD; i++) if (!rp[i] && $urandom_range(0, 1) == 1) new_read(i);
            if (!wp && $urandom_range(0, 4) < 2) new_write();
            any = wp;
            for (int i = 0; i < NRD; i++) any |= rp[i];
            if (!any) new_read(int'($urandom_range(0, NRD - 1)));
            pick(w);
            txn(w, 1'b1, 1'b1);
        end
        drain();

        // reset during beat 5 of a client 0 line
        rp[0] = 1'b1; ra[0] = 64'h8000_1000; rb[0] = 1'b1; rl[0] = 3'd3;
        m_ready = 1'b0;
        apply();
        #1;
        chk("pre_rst_idle", m_req, 0);
        pick(w);
        tick();
        chk("pre_rst_grant", m_addr, ra[0]);
        for (int b = 0; b < 4; b++) begin
            m_ready = 1'b1; m_last = 1'b0;
            m_rdata = {32'($urandom), 32'($urandom)};
            #1;
            chk("pre_rst_beat", c_rd_ready, 2'b01);
            tick();
        end
        m_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_mreq", m_req, 0);
        chk("mid_rst_rdy", c_rd_ready, 0);
        chk("mid_rst_last", c_rd_last, 0);
        chk("mid_rst_wrdy", wr_ready, 0);
        rr  = 0;
        wrl = 1'b0;
        new_read(1);
        pick(w);
        txn(w, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
